log2_misr_capture: RTL
======================

// Module: log2_misr_capture
// PURPOSE
//  Sequential response compactor directly downstream of the combinational log2 netlist (top: a[31:0] -> result[31:0]).
//  Accepts one 32-bit result word per applied pattern over a valid/ready handshake.
//  Folds each word into a 32-bit MISR signature and counts accepted patterns.
//  After a programmed number of patterns, compares the signature to a golden value and flags pass/fail.
//  The fault-sensitivity flow uses this per-fault detect decision instead of bit-by-bit $display dumps.
// PARAMETERS
//  DW        32            result word width; must equal the log2 result width
//  CW        16            pattern counter width
//  MISR_POLY 32'h04C11DB7  feedback polynomial, taps excluding x^32
//  MISR_SEED 32'hFFFFFFFF  signature value loaded at start
// PORTS
//  clk          in   1    single clock, rising edge
//  rst          in   1    asynchronous, active-high reset
//  start        in   1    begin a capture run; sampled in IDLE or DONE only
//  num_patterns in   CW   patterns in the run; latched on accepted start
//  res_valid    in   1    res_data holds a log2 result for the current pattern
//  res_data     in   DW   log2 result word (result[DW-1:0])
//  res_ready    out  1    block accepts res_data this cycle
//  golden_sig   in   DW   expected fault-free signature; sampled on the DONE entry cycle
//  busy         out  1    high in RUN
//  done         out  1    high in DONE; held until next start or reset
//  pass         out  1    signature == golden_sig; valid while done=1
//  signature    out  DW   current MISR value
//  pat_count    out  CW   patterns accepted in the current run
// BEHAVIOUR
//  - All outputs are registered. Reset: state=IDLE, res_ready=0, busy=0, done=0, pass=0, signature=0, pat_count=0.
//  - Reset is asynchronous; assertion mid-run aborts immediately to the reset values. No partial signature survives.
//  - FSM IDLE -> RUN: start=1 and num_patterns!=0. Latch num_patterns, signature<=MISR_SEED, pat_count<=0.
//  - FSM IDLE -> DONE: start=1 and num_patterns==0. signature<=MISR_SEED, pass<=(MISR_SEED==golden_sig).
//  - RUN: res_ready=1 while pat_count < latched count. A transfer occurs when res_valid & res_ready.
//  - On transfer: sig <= {sig[DW-2:0],1'b0} ^ (sig[DW-1] ? MISR_POLY : 0) ^ res_data; pat_count++.
//  - Last transfer (pat_count==N-1): next state DONE; res_ready deasserts the following cycle.
//  - DONE entry compares against the updated signature. Latency from last transfer to done=1: 1 cycle.
//  - res_valid with res_ready=0 is ignored; no data is consumed.
//  - res_valid gaps (res_valid=0) in RUN: state and signature hold. No timeout.
//  - start in RUN is ignored. start in DONE restarts exactly as from IDLE; done drops the next cycle.
//  - pat_count never wraps: N <= 2^CW-1 by construction, and acceptance stops at N.
//  - res_data X or Z on a transfer is a checker error in simulation; the RTL does not filter it.
// STRUCTURE
//  - Shared package log2_test_pkg holds:
//    - the state typedef {IDLE, RUN, DONE};
//    - MISR_POLY and MISR_SEED constants;
//    - DW=32 for the log2 datapath.
//  - Sub-module misr32: combinational next-signature function (sig, data, poly -> sig_next), reused by the golden-signature generator.
//  - This module holds the FSM, counter, and registers only.
// TESTING
//  - Reset then start, N=1, res_data=32'h0 -> signature=32'hFB3EE249 one cycle after the transfer; done=1.
//    With golden_sig=32'hFB3EE249, pass=1; with any other value, pass=0.
//  - start with N=0 -> DONE in 1 cycle, signature=32'hFFFFFFFF, res_ready never asserts, pat_count=0.
//  - N=4, res_valid toggled 1,0,1,1,0,1 -> exactly 4 transfers, pat_count=4.
//    Signature equals the misr32 reference model; a 5th valid is not accepted.
//  - rst pulsed after 2 of 4 transfers -> outputs return to reset values at once.
//    A new start with N=4 yields the same signature as an uninterrupted run.
//  - start held high through RUN -> no restart. After DONE, one start pulse restarts: done=0 and signature reseeded next cycle.
//  - Single-bit flip in one result word (result[31] 0->1) vs the golden run -> pass=0.

Source files
------------

// File: rtl/log2_test_pkg.sv
// Shared definitions for the log2 response-compaction datapath.
package log2_test_pkg;

  localparam int unsigned DW = 32;

  localparam logic [31:0] MISR_POLY = 32'h04C11DB7;
  localparam logic [31:0] MISR_SEED = 32'hFFFFFFFF;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StRun  = 2'd1;
  localparam state_t StDone = 2'd2;

endpackage

// File: rtl/log2_misr_capture_if.sv
// Control, result-stream and status signals of the log2 MISR capture block.
interface log2_misr_capture_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned CW = 16
);
  logic          start;
  logic [CW-1:0] num_patterns;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic          res_ready;
  logic [DW-1:0] golden_sig;
  logic          busy;
  logic          done;
  logic          pass;
  logic [DW-1:0] signature;
  logic [CW-1:0] pat_count;

  modport master (
    output start, num_patterns, res_valid, res_data, golden_sig,
    input  res_ready, busy, done, pass, signature, pat_count
  );

  modport slave (
    input  start, num_patterns, res_valid, res_data, golden_sig,
    output res_ready, busy, done, pass, signature, pat_count
  );
endinterface

// File: rtl/misr32.sv
// Combinational MISR step: Galois-style shift with polynomial feedback, then fold in data.
module misr32 #(
  parameter int unsigned DW = 32
) (
  input  logic [DW-1:0] sig_i,
  input  logic [DW-1:0] data_i,
  input  logic [DW-1:0] poly_i,
  output logic [DW-1:0] sig_next_o
);
  always_comb begin
    sig_next_o = {sig_i[DW-2:0], 1'b0} ^ (sig_i[DW-1] ? poly_i : '0) ^ data_i;
  end
endmodule

// File: rtl/log2_misr_capture.sv
// Compacts a run of log2 result words into a MISR signature and flags golden match.
module log2_misr_capture #(
  parameter int unsigned      DW        = log2_test_pkg::DW,
  parameter int unsigned      CW        = 16,
  parameter logic [DW-1:0]    MISR_POLY = log2_test_pkg::MISR_POLY,
  parameter logic [DW-1:0]    MISR_SEED = log2_test_pkg::MISR_SEED
) (
  input logic               clk,
  input logic               rst,
  log2_misr_capture_if.slave bus
);
  import log2_test_pkg::*;

  state_t        state_q, state_d;
  logic [CW-1:0] num_q, num_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] sig_q, sig_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [DW-1:0] sig_next;

  misr32 #(.DW(DW)) u_misr (
    .sig_i      (sig_q),
    .data_i     (bus.res_data),
    .poly_i     (MISR_POLY),
    .sig_next_o (sig_next)
  );

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          sig_d  = MISR_SEED;
          cnt_d  = '0;
          num_d  = bus.num_patterns;
          if (bus.num_patterns != '0) begin
            state_d = StRun;
            ready_d = 1'b1;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            pass_d  = 1'b0;
          end else begin
            // Empty run: the seed itself is the signature to judge.
            state_d = StDone;
            done_d  = 1'b1;
            pass_d  = (MISR_SEED == bus.golden_sig);
          end
        end
      end
      StRun: begin
        if (bus.res_valid && ready_q) begin
          sig_d = sig_next;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == num_q - CW'(1)) begin
            state_d = StDone;
            ready_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (sig_next == bus.golden_sig);
          end
        end
      end
      default: begin
        state_d = StIdle;
        ready_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        pass_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      num_q   <= '0;
      cnt_q   <= '0;
      sig_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.res_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.signature = sig_q;
  assign bus.pat_count = cnt_q;

endmodule
